// File: rtl/rbot_pkg.sv
// Shared types and constants for the cube-solver motion path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rbot_pkg;

   // Move code: face in [3:1], direction in [0] (0 = clockwise, 1 = counter-clockwise)
   localparam int MOVE_W = 4;
   localparam logic [MOVE_W-1:0] MV_U_CW  = 4'h0;
   localparam logic [MOVE_W-1:0] MV_U_CCW = 4'h1;
   localparam logic [MOVE_W-1:0] MV_D_CW  = 4'h2;
   localparam logic [MOVE_W-1:0] MV_D_CCW = 4'h3;
   localparam logic [MOVE_W-1:0] MV_F_CW  = 4'h4;
   localparam logic [MOVE_W-1:0] MV_F_CCW = 4'h5;
   localparam logic [MOVE_W-1:0] MV_B_CW  = 4'h6;
   localparam logic [MOVE_W-1:0] MV_B_CCW = 4'h7;
   localparam logic [MOVE_W-1:0] MV_L_CW  = 4'h8;
   localparam logic [MOVE_W-1:0] MV_L_CCW = 4'h9;
   localparam logic [MOVE_W-1:0] MV_R_CW  = 4'hA;
   localparam logic [MOVE_W-1:0] MV_R_CCW = 4'hB;

   // 25 MHz system clock
   localparam int CLKS_PER_MS_DEFAULT = 25000;

   // Sequencer state encoding
   localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
   localparam logic [2:0] ST_ISSUE_ENC  = 3'd1;
   localparam logic [2:0] ST_WAIT_ENC   = 3'd2;
   localparam logic [2:0] ST_SETTLE_ENC = 3'd3;
   localparam logic [2:0] ST_FAULT_ENC  = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE_ENC,
      S_ISSUE  = ST_ISSUE_ENC,
      S_WAIT   = ST_WAIT_ENC,
      S_SETTLE = ST_SETTLE_ENC,
      S_FAULT  = ST_FAULT_ENC
   } seq_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/move_sequencer_ms_timer.sv
// Runtime-loadable millisecond timer; expired pulses once per load.
// Latency: load of N ms expires N*CLKS_PER_MS cycles after the load cycle; N=0 expires next cycle.
// Backpressure: none; a load while running restarts the count.
module ms_timer #(
   parameter int CLKS_PER_MS = 25000,
   parameter int MS_W        = 12
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            load,
   input  logic [MS_W-1:0] load_ms,
   output logic            expired
);
   localparam int CYC_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
   localparam logic [CYC_W-1:0] CYC_TOP = CYC_W'(CLKS_PER_MS - 1);

   logic [CYC_W-1:0] cyc_q, cyc_d;
   logic [MS_W-1:0]  ms_q, ms_d;
   logic             run_q, run_d;

   // Counts remaining (ms, cycle) down to (0,0); that terminal cycle is the expiry
   assign expired = run_q && (cyc_q == '0) && (ms_q == '0);

   // Next-count logic: load wins over everything, expiry stops the timer
   always_comb begin
      cyc_d = cyc_q;
      ms_d  = ms_q;
      run_d = run_q;
      if (load) begin
         run_d = 1'b1;
         if (load_ms == '0) begin
            ms_d  = '0;
            cyc_d = '0;
         end else begin
            ms_d  = load_ms - MS_W'(1);
            cyc_d = CYC_TOP;
         end
      end else if (expired) begin
         run_d = 1'b0;
      end else if (run_q) begin
         if (cyc_q == '0) begin
            cyc_d = CYC_TOP;
            ms_d  = ms_q - MS_W'(1);
         end else begin
            cyc_d = cyc_q - CYC_W'(1);
         end
      end
   end

   // Counter registers
   always_ff @(posedge clock) begin
      if (reset) begin
         cyc_q <= '0;
         ms_q  <= '0;
         run_q <= 1'b0;
      end else begin
         cyc_q <= cyc_d;
         ms_q  <= ms_d;
         run_q <= run_d;
      end
   end

endmodule

// File: rtl/move_sequencer.sv
// Queues move codes and runs each through start pulse, motor wait (with timeout) and settle.
// Latency: accept-to-motor_start 2 cycles; motor_done to next motor_start SETTLE_MS*CLKS_PER_MS+2.
// Backpressure: move_ready low when the queue is full or after a motor timeout fault.
module move_sequencer
   import rbot_pkg::*;
#(
   parameter int CLKS_PER_MS = CLKS_PER_MS_DEFAULT,
   parameter int SETTLE_MS   = 250,
   parameter int TIMEOUT_MS  = 2000,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              move_valid,
   input  logic [MOVE_W-1:0] move_code,
   output logic              move_ready,
   output logic              motor_start,
   output logic [MOVE_W-1:0] motor_cmd,
   input  logic              motor_done,
   output logic              busy,
   output logic              seq_done,
   output logic              fault
);
   localparam int MS_W  = $clog2(max_int(SETTLE_MS, TIMEOUT_MS) + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   seq_state_t        state_q, state_d;
   logic              motor_start_q, motor_start_d;
   logic [MOVE_W-1:0] motor_cmd_q, motor_cmd_d;
   logic              seq_done_q, seq_done_d;
   logic              fault_q, fault_d;

   logic [MOVE_W-1:0] fifo_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic              push, pop, flush;
   logic              tmr_load, tmr_expired;
   logic [MS_W-1:0]   tmr_ms;

   // Decoded purely from registers so upstream sees no input-to-output path
   assign move_ready  = (count_q != CNT_W'(FIFO_DEPTH)) && (state_q != S_FAULT);
   assign busy        = (state_q != S_IDLE) || (count_q != '0);
   assign push        = move_valid && move_ready;
   assign motor_start = motor_start_q;
   assign motor_cmd   = motor_cmd_q;
   assign seq_done    = seq_done_q;
   assign fault       = fault_q;

   ms_timer #(
      .CLKS_PER_MS (CLKS_PER_MS),
      .MS_W        (MS_W)
   ) u_timer (
      .clock   (clock),
      .reset   (reset),
      .load    (tmr_load),
      .load_ms (tmr_ms),
      .expired (tmr_expired)
   );

   // Sequencer next-state, registered-output and queue-pointer decode
   always_comb begin
      state_d       = state_q;
      motor_start_d = 1'b0;
      motor_cmd_d   = motor_cmd_q;
      seq_done_d    = 1'b0;
      fault_d       = fault_q;
      pop           = 1'b0;
      flush         = 1'b0;
      tmr_load      = 1'b0;
      tmr_ms        = MS_W'(SETTLE_MS);
      case (state_q)
         S_IDLE: begin
            // Pop on the way into ISSUE so motor_start and motor_cmd appear together
            if (count_q != '0) begin
               pop           = 1'b1;
               motor_cmd_d   = fifo_q[rd_ptr_q];
               motor_start_d = 1'b1;
               state_d       = S_ISSUE;
            end
         end
         S_ISSUE: begin
            tmr_load = 1'b1;
            tmr_ms   = MS_W'(TIMEOUT_MS);
            state_d  = S_WAIT;
         end
         S_WAIT: begin
            // motor_done is checked first so a coincident expiry is not a fault
            if (motor_done) begin
               if (SETTLE_MS == 0) begin
                  // Zero settle: skip the settle state so the next start is 2 cycles out
                  state_d    = S_IDLE;
                  seq_done_d = (count_q == '0);
               end else begin
                  tmr_load = 1'b1;
                  state_d  = S_SETTLE;
               end
            end else if (tmr_expired) begin
               state_d = S_FAULT;
               fault_d = 1'b1;
               flush   = 1'b1;
            end
         end
         S_SETTLE: begin
            if (tmr_expired) begin
               state_d    = S_IDLE;
               seq_done_d = (count_q == '0);
            end
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // State, outputs and queue pointers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= S_IDLE;
         motor_start_q <= 1'b0;
         motor_cmd_q   <= '0;
         seq_done_q    <= 1'b0;
         fault_q       <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
      end else begin
         state_q       <= state_d;
         motor_start_q <= motor_start_d;
         motor_cmd_q   <= motor_cmd_d;
         seq_done_q    <= seq_done_d;
         fault_q       <= fault_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
      end
   end

   // Queue storage; entries are only meaningful below count, so no reset needed
   always_ff @(posedge clock) begin
      if (push && !flush) fifo_q[wr_ptr_q] <= move_code;
   end

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: event-time reference model plus a zero-settle instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_move_sequencer;
   import rbot_pkg::*;

   localparam int C  = 4;
   localparam int S  = 3;
   localparam int TO = 5;
   localparam int DEPTH = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic move_valid = 1'b0;
   logic [3:0] move_code = 4'h0;
   logic motor_done = 1'b0;
   logic move_ready, motor_start, busy, seq_done, fault;
   logic [3:0] motor_cmd;

   logic z_valid = 1'b0;
   logic [3:0] z_code = 4'h0;
   logic z_done = 1'b0;
   logic z_ready, z_start, z_busy, z_sd, z_fault;
   logic [3:0] z_cmd;

   always #5 clock = ~clock;

   move_sequencer #(.CLKS_PER_MS(C), .SETTLE_MS(S), .TIMEOUT_MS(TO), .FIFO_DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset), .move_valid(move_valid), .move_code(move_code),
      .move_ready(move_ready), .motor_start(motor_start), .motor_cmd(motor_cmd),
      .motor_done(motor_done), .busy(busy), .seq_done(seq_done), .fault(fault));

   move_sequencer #(.CLKS_PER_MS(C), .SETTLE_MS(0), .TIMEOUT_MS(TO), .FIFO_DEPTH(DEPTH)) dut0 (
      .clock(clock), .reset(reset), .move_valid(z_valid), .move_code(z_code),
      .move_ready(z_ready), .motor_start(z_start), .motor_cmd(z_cmd),
      .motor_done(z_done), .busy(z_busy), .seq_done(z_sd), .fault(z_fault));

   int n_chk = 0;
   int n_fail = 0;
   int now = 0;
   bit chk_en = 1'b0;
   int done_at = -1;

   // Reference model: event times derived from the move rules
   int qm[$];
   logic [3:0] m_cmd;
   bit m_idle, m_faulted;
   int m_issue_t, m_win_lo, m_win_hi, m_idle_t, m_sdchk_t, m_sd_t, m_fault_t;

   // Zero-settle instance expectations
   bit v0 = 1'b0, d0 = 1'b0;
   logic [3:0] c0 = 4'h0;
   int e0a = -1, e0b = -1, e0sd = -1;

   task automatic model_reset();
      qm.delete();
      m_cmd = 4'h0; m_idle = 1'b1; m_faulted = 1'b0;
      m_issue_t = -1; m_win_lo = -1; m_win_hi = -2;
      m_idle_t = -1; m_sdchk_t = -1; m_sd_t = -1; m_fault_t = -1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      n_chk++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, now, obs, exp_v);
      end
   endtask

   task automatic step(input bit v, input logic [3:0] c, input bit d, input bit r);
      bit e_start, e_sd, e_ready, e_busy, psh;
      if (m_idle_t == now) m_idle = 1'b1;
      e_start = (m_issue_t == now);
      e_sd    = (m_sd_t == now);
      e_ready = !m_faulted && (qm.size() != DEPTH);
      e_busy  = !m_idle || (qm.size() != 0);
      if (chk_en) begin
         chk("motor_start", 8'(motor_start), 8'(e_start));
         chk("motor_cmd",   8'(motor_cmd),   8'(m_cmd));
         chk("seq_done",    8'(seq_done),    8'(e_sd));
         chk("fault",       8'(fault),       8'(m_faulted));
         chk("move_ready",  8'(move_ready),  8'(e_ready));
         chk("busy",        8'(busy),        8'(e_busy));
         chk("z_motor_start", 8'(z_start), 8'((now == e0a) || (now == e0b)));
         chk("z_seq_done",    8'(z_sd),    8'(now == e0sd));
         chk("z_fault",       8'(z_fault), 8'h00);
         if (now == e0a) chk("z_motor_cmd", 8'(z_cmd), 8'h09);
         if (now == e0b) chk("z_motor_cmd", 8'(z_cmd), 8'h0A);
      end
      move_valid = v; move_code = c; motor_done = d; reset = r;
      z_valid = v0; z_code = c0; z_done = d0;
      if (r) begin
         model_reset();
      end else begin
         psh = v && e_ready;
         if (m_sdchk_t == now && qm.size() == 0) m_sd_t = now + 1;
         if (m_idle && qm.size() > 0) begin
            m_cmd = 4'(qm.pop_front());
            m_idle = 1'b0;
            m_issue_t = now + 1;
            m_win_lo = now + 2;
            m_win_hi = now + 1 + TO * C;
         end else if (now >= m_win_lo && now <= m_win_hi) begin
            if (d) begin
               m_win_hi = -2;
               m_idle_t = now + S * C + 1;
               m_sdchk_t = now + S * C;
            end else if (now == m_win_hi) begin
               m_win_hi = -2;
               m_faulted = 1'b1;
               m_fault_t = now + 1;
               qm.delete();
               psh = 1'b0;
            end
         end
         if (psh) qm.push_back(int'(c));
      end
      @(posedge clock);
      #1;
      now++;
      v0 = 1'b0; d0 = 1'b0;
   endtask

   task automatic run(input int n, input int vpct, input int dlo, input int dhi,
                      input int stray, input bit rnd_rst);
      for (int i = 0; i < n; i++) begin
         bit v, d, r;
         logic [3:0] c;
         if (m_issue_t == now) done_at = now + int'($urandom_range(dlo, dhi));
         v = int'($urandom_range(0, 99)) < vpct;
         c = 4'($urandom_range(0, 15));
         d = (now == done_at) || (int'($urandom_range(0, 99)) < stray);
         r = rnd_rst && ((m_faulted && now > m_fault_t + 3) || ($urandom_range(0, 299) == 0));
         step(v, c, d, r);
      end
   endtask

   initial begin
      model_reset();
      step(1'b0, 4'h0, 1'b0, 1'b1);
      step(1'b0, 4'h0, 1'b0, 1'b1);
      chk_en = 1'b1;
      run(3, 0, 1, 1, 0, 1'b0);

      // Zero-settle instance: two moves, starts at t+2 and done+2, seq_done after the last
      e0a = now + 2; e0b = now + 8; e0sd = now + 12;
      for (int k = 0; k < 16; k++) begin
         v0 = (k == 0) || (k == 1);
         c0 = (k == 0) ? MV_L_CCW : MV_R_CW;
         d0 = (k == 6) || (k == 11);
         step(1'b0, 4'h0, 1'b0, 1'b0);
      end

      // Single move, motor_done 8 cycles after start
      step(1'b1, MV_D_CCW, 1'b0, 1'b0);
      run(40, 0, 8, 8, 0, 1'b0);

      // Back-to-back pushes 1..4
      for (int k = 1; k <= 4; k++) step(1'b1, 4'(k), 1'b0, 1'b0);
      run(80, 0, 3, 3, 0, 1'b0);

      // Fill the queue behind a slow move, then keep offering while it drains
      step(1'b1, MV_F_CW, 1'b0, 1'b0);
      run(8, 100, 15, 15, 0, 1'b0);
      run(60, 30, 15, 15, 0, 1'b0);
      run(120, 0, 2, 2, 0, 1'b0);

      // Timeout: no done, then ignored pushes and stray dones, then reset
      step(1'b1, MV_B_CW, 1'b0, 1'b0);
      run(30, 0, 99, 99, 0, 1'b0);
      run(10, 100, 99, 99, 50, 1'b0);
      step(1'b0, 4'h0, 1'b0, 1'b1);
      run(3, 0, 1, 1, 0, 1'b0);

      // motor_done exactly on the timeout expiry cycle
      step(1'b1, MV_U_CCW, 1'b0, 1'b0);
      run(50, 0, TO * C, TO * C, 0, 1'b0);

      // Reset while settling with two moves queued
      step(1'b1, MV_R_CCW, 1'b0, 1'b0);
      run(6, 0, 2, 2, 0, 1'b0);
      step(1'b1, MV_F_CCW, 1'b0, 1'b0);
      step(1'b1, MV_B_CCW, 1'b0, 1'b0);
      step(1'b0, 4'h0, 1'b0, 1'b0);
      step(1'b0, 4'h0, 1'b0, 1'b1);
      run(6, 0, 2, 2, 0, 1'b0);

      // Randomized traffic with occasional timeouts and resets
      run(1500, 35, 1, 22, 3, 1'b1);
      run(120, 0, 2, 2, 0, 1'b1);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
